mu_alu_arbiter: RTL and testbench
=================================

Name: mu_alu_arbiter

Overview:
- Round-robin scheduler sharing one Q16.16 ALU between NUM_REQ requesters (e.g. partition engine, μ-cost accountant, CLAIM decoder).
- Latches the winner's op and operands and drives the ALU's level valid/ready handshake: valid held until ready, then valid dropped until ready clears.
- Returns result, overflow and a timeout flag to the winner as a one-cycle done pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_IDW, 2, width of owner index, equals ceil(log2(NUM_REQ))
TIMEOUT_CYC, 15, max cycles in BUSY or DRAIN before forced abort (1..2^TO_W-1)
TO_W, 4, timeout counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_op  input  3*NUM_REQ  ALU op per requester, slice i = [3i+2:3i]
req_a  input  32*NUM_REQ  operand A per requester, slice i = [32i+31:32i]
req_b  input  32*NUM_REQ  operand B per requester, same slicing
done  output  NUM_REQ  one-hot, one-cycle completion pulse to owner
rsp_result  output  32  result, valid while done is high
rsp_overflow  output  1  ALU overflow, valid with done
rsp_timeout  output  1  1 = op aborted by timeout, valid with done
alu_valid  output  1  ALU request
alu_op  output  3  ALU op
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_ready  input  1  ALU ready
alu_result  input  32  ALU result
alu_overflow  input  1  ALU overflow
busy  output  1  1 when state != IDLE
owner  output  REQ_IDW  index of current/last grantee
op_count  output  16  completed ops (including timeouts), saturates at 16'hFFFF

Behaviour:
Reset (async, rst_n=0):
- All outputs 0. state=IDLE, timeout counter 0.
- last_owner=NUM_REQ-1, so requester 0 wins first.

States: IDLE, BUSY, DRAIN.

IDLE:
- If any req bit set, grant the first set bit searching from (last_owner+1) mod NUM_REQ upward with wrap.
- Register owner/last_owner and latch alu_op/alu_a/alu_b from the owner's slices.
- alu_valid<=1, counter<=0, go BUSY.
- No request: stay, alu_valid=0.

BUSY:
- alu_valid held 1; alu_op/alu_a/alu_b held constant (requester inputs are not re-sampled).
- alu_ready=1: rsp_result<=alu_result, rsp_overflow<=alu_overflow, rsp_timeout<=0, done[owner]<=1 for one cycle, alu_valid<=0, op_count+1, counter<=0, go DRAIN.
- Otherwise counter+1. When counter reaches TIMEOUT_CYC: done pulse with rsp_result=0, rsp_overflow=0, rsp_timeout=1, alu_valid<=0, go DRAIN.

DRAIN:
- alu_valid=0. When alu_ready=0, go IDLE.
- Else counter+1; at TIMEOUT_CYC force IDLE. No done pulse, no flag.
- Prevents re-issue while the ALU still shows a stale ready.

Timing with the standard ALU (ready registered one cycle after valid):
- req seen in IDLE at cycle t; alu_valid=1 at t+1; alu_ready=1 at t+2.
- done and result at t+3; alu_ready=0 at t+4; IDLE at t+5.
- Earliest next grant evaluated at t+5. Back-to-back throughput: one op per 5 cycles.

Boundary rules:
- req may drop after grant: the op still completes and done still pulses to that index.
- Requester re-raising req right after done is re-eligible but ranks lowest.
- rsp_* hold their values until the next completion; done is 0 except the pulse cycle.
- alu_ready=1 while in IDLE is ignored.
- Reset mid-op aborts immediately: no done pulse; alu_valid drops asynchronously.
- op_count does not wrap.

Test Plan:
- Single op: req=4'b0001, op=0 (ADD), a=32'h00010000, b=32'h00020000 -> done[0] at t+3, rsp_result=32'h00030000, rsp_overflow=0, busy high t+1..t+4.
- Round robin: req=4'b1111 held with distinct ops -> grants in order 0,1,2,3,0, each done 5 cycles apart, op_count=5 after fifth done.
- Fairness across wrap: last owner 3, req=4'b1001 -> owner=0 next; then req=4'b1001 again -> owner=3.
- Timeout: ALU model never asserts ready -> after TIMEOUT_CYC=15 cycles in BUSY, done[owner]=1, rsp_timeout=1, rsp_result=0, then IDLE; next op completes normally with rsp_timeout=0.
- Stuck ready: alu_ready held 1 after completion -> DRAIN exits after 15 cycles without a done pulse; no new alu_valid is issued before that.
- Reset mid-op: rst_n low during BUSY -> alu_valid, done, busy, op_count are 0 immediately; after release requester 0 wins first.

Source files
------------

// File: rtl/mu_alu_arbiter_if.sv
// ALU-side handshake bundle between the arbiter (master) and the shared Q16.16 ALU (slave).
interface mu_alu_arbiter_if;
    logic        alu_valid;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ready;
    logic [31:0] alu_result;
    logic        alu_overflow;

    modport master (
        output alu_valid, alu_op, alu_a, alu_b,
        input  alu_ready, alu_result, alu_overflow
    );

    modport slave (
        input  alu_valid, alu_op, alu_a, alu_b,
        output alu_ready, alu_result, alu_overflow
    );
endinterface

// File: rtl/mu_alu_arbiter.sv
// Round-robin scheduler sharing one Q16.16 ALU between NUM_REQ requesters.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no op in flight; pick next requester after last_owner
// ST_BUSY  | alu_valid held with latched op/operands, waiting for alu_ready
// ST_DRAIN | op finished or aborted; wait for alu_ready to fall before IDLE
//
// The BUSY/DRAIN timer is a down-counter loaded with TIMEOUT_CYC on entry;
// reaching the terminal count of 1 without the awaited event forces the exit,
// so at most TIMEOUT_CYC cycles are spent in either state.
module mu_alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_IDW     = 2,
    parameter int TIMEOUT_CYC = 15,
    parameter int TO_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [3*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      done,
    output logic [31:0]             rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_timeout,
    mu_alu_arbiter_if.master        alu,
    output logic                    busy,
    output logic [REQ_IDW-1:0]      owner,
    output logic [15:0]             op_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [TO_W-1:0] TMR_LOAD = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TMR_TC   = TO_W'(1);

    logic [1:0]          state_q, state_d;
    logic [TO_W-1:0]     tmr_q, tmr_d;
    logic [REQ_IDW-1:0]  owner_q, owner_d;
    logic [REQ_IDW-1:0]  last_owner_q, last_owner_d;
    logic                valid_q, valid_d;
    logic [2:0]          op_q, op_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [31:0]         result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         op_count_q, op_count_d;

    logic                grant_vld;
    logic [REQ_IDW-1:0]  grant_idx;
    logic [15:0]         op_count_inc;

    // Round-robin search: first set req bit starting just after last_owner, with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_vld && req[(int'(last_owner_q) + i) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = REQ_IDW'((int'(last_owner_q) + i) % NUM_REQ);
            end
        end
    end

    assign op_count_inc = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;

    // Next-state, operand latch and response logic for the IDLE/BUSY/DRAIN sequence.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        valid_d      = valid_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        done_d       = '0;
        result_d     = result_q;
        ovf_d        = ovf_q;
        tmo_d        = tmo_q;
        op_count_d   = op_count_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (grant_vld) begin
                    owner_d      = grant_idx;
                    last_owner_d = grant_idx;
                    op_d         = req_op[32'(grant_idx) * 3 +: 3];
                    a_d          = req_a[32'(grant_idx) * 32 +: 32];
                    b_d          = req_b[32'(grant_idx) * 32 +: 32];
                    valid_d      = 1'b1;
                    tmr_d        = TMR_LOAD;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (alu.alu_ready) begin
                    result_d         = alu.alu_result;
                    ovf_d            = alu.alu_overflow;
                    tmo_d            = 1'b0;
                    done_d[owner_q]  = 1'b1;
                    valid_d          = 1'b0;
                    op_count_d       = op_count_inc;
                    tmr_d            = TMR_LOAD;
                    state_d          = ST_DRAIN;
                end else if (tmr_q <= TMR_TC) begin
                    result_d         = '0;
                    ovf_d            = 1'b0;
                    tmo_d            = 1'b1;
                    done_d[owner_q]  = 1'b1;
                    valid_d          = 1'b0;
                    op_count_d       = op_count_inc;
                    tmr_d            = TMR_LOAD;
                    state_d          = ST_DRAIN;
                end else begin
                    tmr_d = tmr_q - TMR_TC;
                end
            end
            ST_DRAIN: begin
                valid_d = 1'b0;
                if (!alu.alu_ready || tmr_q <= TMR_TC) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_TC;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any op in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= REQ_IDW'(NUM_REQ - 1);
            valid_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            done_q       <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            valid_q      <= valid_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            done_q       <= done_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu.alu_valid = valid_q;
    assign alu.alu_op    = op_q;
    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;
    assign done          = done_q;
    assign rsp_result    = result_q;
    assign rsp_overflow  = ovf_q;
    assign rsp_timeout   = tmo_q;
    assign busy          = (state_q != ST_IDLE);
    assign owner         = owner_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_mu_alu_arbiter.sv
// Directed bench for mu_alu_arbiter: completions are checked against a queue of
// expected responses pushed as each request is issued.
module tb_mu_alu_arbiter;

    localparam int NUM_REQ = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [3*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    done;
    logic [31:0]           rsp_result;
    logic                  rsp_overflow;
    logic                  rsp_timeout;
    logic                  busy;
    logic [1:0]            owner;
    logic [15:0]           op_count;

    mu_alu_arbiter_if alu_if ();

    mu_alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .done         (done),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .alu          (alu_if),
        .busy         (busy),
        .owner        (owner),
        .op_count     (op_count)
    );

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        ovf;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   n_push    = 0;
    int   done_seen = 0;
    int   alu_mode  = 0;   // 0 normal, 1 never ready, 2 ready sticks high

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: ready registered one cycle after valid, result registered alongside.
    logic [31:0] alu_res;
    logic        alu_ovf;
    always @* begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_if.alu_op)
            3'd0: begin
                alu_res = alu_if.alu_a + alu_if.alu_b;
                alu_ovf = (alu_if.alu_a[31] == alu_if.alu_b[31]) && (alu_res[31] != alu_if.alu_a[31]);
            end
            3'd1: begin
                alu_res = alu_if.alu_a - alu_if.alu_b;
                alu_ovf = (alu_if.alu_a[31] != alu_if.alu_b[31]) && (alu_res[31] != alu_if.alu_a[31]);
            end
            3'd2:    alu_res = alu_if.alu_a ^ alu_if.alu_b;
            3'd3:    alu_res = alu_if.alu_a & alu_if.alu_b;
            default: alu_res = alu_if.alu_a | alu_if.alu_b;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_if.alu_ready    <= 1'b0;
            alu_if.alu_result   <= '0;
            alu_if.alu_overflow <= 1'b0;
        end else begin
            case (alu_mode)
                1:       alu_if.alu_ready <= 1'b0;
                2:       alu_if.alu_ready <= alu_if.alu_ready | alu_if.alu_valid;
                default: alu_if.alu_ready <= alu_if.alu_valid;
            endcase
            alu_if.alu_result   <= alu_res;
            alu_if.alu_overflow <= alu_ovf;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*i +: 3] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] res, input logic ovf, input logic tmo);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.ovf = ovf;
        e.tmo = tmo;
        sb.push_back(e);
        n_push++;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && done !== '0) begin
            done_seen++;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_done observed=%b expected=no_pulse", done);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_done_vec", 32'(done), 32'd1 << mon_e.idx);
                chk("sb_result", rsp_result, mon_e.res);
                chk("sb_overflow", 32'(rsp_overflow), 32'(mon_e.ovf));
                chk("sb_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        req_op = '0;
        req_a  = '0;
        req_b  = '0;

        // Reset values
        step(2);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(alu_if.alu_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_timeout", 32'(rsp_timeout), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single ADD from requester 0, req dropped and operands changed after grant
        set_slot(0, 3'd0, 32'h0001_0000, 32'h0002_0000);
        req = 4'b0001;
        push_exp(0, 32'h0003_0000, 1'b0, 1'b0);
        chk("single_t0_busy", 32'(busy), 32'd0);
        step(1);
        chk("single_t1_busy", 32'(busy), 32'd1);
        chk("single_t1_valid", 32'(alu_if.alu_valid), 32'd1);
        chk("single_t1_op", 32'(alu_if.alu_op), 32'd0);
        chk("single_t1_a", alu_if.alu_a, 32'h0001_0000);
        chk("single_t1_b", alu_if.alu_b, 32'h0002_0000);
        chk("single_t1_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        set_slot(0, 3'd4, 32'hDEAD_0000, 32'hBEEF_0000);
        step(1);
        chk("single_t2_a_held", alu_if.alu_a, 32'h0001_0000);
        chk("single_t2_valid", 32'(alu_if.alu_valid), 32'd1);
        chk("single_t2_done", 32'(done), 32'd0);
        step(1);
        chk("single_t3_done", 32'(done), 32'b0001);
        chk("single_t3_result", rsp_result, 32'h0003_0000);
        chk("single_t3_valid", 32'(alu_if.alu_valid), 32'd0);
        step(1);
        chk("single_t4_busy", 32'(busy), 32'd1);
        chk("single_t4_done", 32'(done), 32'd0);
        chk("single_t4_result_hold", rsp_result, 32'h0003_0000);
        step(1);
        chk("single_t5_busy", 32'(busy), 32'd0);
        chk("single_op_count", 32'(op_count), 32'd1);

        // Fairness across the wrap: 3, then 0, then 3 with req=1001 held
        set_slot(0, 3'd0, 32'h0001_0000, 32'h0002_0000);
        set_slot(3, 3'd3, 32'h1234_5678, 32'h0000_FFFF);
        req = 4'b1000;
        push_exp(3, 32'h0000_5678, 1'b0, 1'b0);
        step(1);
        chk("wrap_owner3_first", 32'(owner), 32'd3);
        req = 4'b1001;
        push_exp(0, 32'h0003_0000, 1'b0, 1'b0);
        push_exp(3, 32'h0000_5678, 1'b0, 1'b0);
        step(5);
        chk("wrap_owner0", 32'(owner), 32'd0);
        step(5);
        chk("wrap_owner3", 32'(owner), 32'd3);
        req = 4'b0000;
        step(4);
        chk("wrap_idle", 32'(busy), 32'd0);
        chk("wrap_op_count", 32'(op_count), 32'd4);

        // Timeout: ALU never raises ready
        alu_mode = 1;
        req = 4'b0100;
        push_exp(2, 32'd0, 1'b0, 1'b1);
        step(1);
        chk("tmo_owner", 32'(owner), 32'd2);
        chk("tmo_valid_start", 32'(alu_if.alu_valid), 32'd1);
        req = 4'b0000;
        step(14);
        chk("tmo_no_done_yet", 32'(done), 32'd0);
        chk("tmo_valid_held", 32'(alu_if.alu_valid), 32'd1);
        step(1);
        chk("tmo_done", 32'(done), 32'b0100);
        chk("tmo_flag", 32'(rsp_timeout), 32'd1);
        chk("tmo_valid_drop", 32'(alu_if.alu_valid), 32'd0);
        step(1);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_op_count", 32'(op_count), 32'd5);

        // Normal op after timeout, with signed overflow
        alu_mode = 0;
        set_slot(2, 3'd0, 32'h7FFF_0000, 32'h0001_0000);
        req = 4'b0100;
        push_exp(2, 32'h8000_0000, 1'b1, 1'b0);
        step(1);
        req = 4'b0000;
        step(2);
        chk("post_tmo_done", 32'(done), 32'b0100);
        chk("post_tmo_flag", 32'(rsp_timeout), 32'd0);
        chk("post_tmo_ovf", 32'(rsp_overflow), 32'd1);
        step(2);
        chk("post_tmo_idle", 32'(busy), 32'd0);

        // Stuck ready: DRAIN must time out, no pulse, no re-issue while req is held
        alu_mode = 2;
        set_slot(1, 3'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        req = 4'b0010;
        push_exp(1, 32'h5555_5555, 1'b0, 1'b0);
        step(3);
        chk("stuck_done", 32'(done), 32'b0010);
        for (int k = 4; k <= 17; k++) begin
            step(1);
            chk("stuck_drain_no_done", 32'(done), 32'd0);
            chk("stuck_drain_no_valid", 32'(alu_if.alu_valid), 32'd0);
        end
        chk("stuck_still_drain", 32'(busy), 32'd1);
        req = 4'b0000;
        step(1);
        chk("stuck_drain_exit", 32'(busy), 32'd0);
        chk("stuck_idle_no_done", 32'(done), 32'd0);
        alu_mode = 0;
        step(2);
        chk("stuck_op_count", 32'(op_count), 32'd7);

        // Reset during BUSY: everything clears at once, no pulse
        req = 4'b0100;
        step(1);
        chk("rstmid_busy", 32'(busy), 32'd1);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(alu_if.alu_valid), 32'd0);
        chk("rstmid_busy_clr", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_op_count", 32'(op_count), 32'd0);
        req = 4'b0000;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Round robin with all four requesting: 0,1,2,3,0
        set_slot(0, 3'd0, 32'h0001_0000, 32'h0002_0000);
        set_slot(1, 3'd1, 32'h0005_0000, 32'h0001_8000);
        set_slot(2, 3'd2, 32'h0F0F_0000, 32'h00FF_0000);
        set_slot(3, 3'd3, 32'h1234_5678, 32'h0000_FFFF);
        req = 4'b1111;
        push_exp(0, 32'h0003_0000, 1'b0, 1'b0);
        push_exp(1, 32'h0003_8000, 1'b0, 1'b0);
        push_exp(2, 32'h0FF0_0000, 1'b0, 1'b0);
        push_exp(3, 32'h0000_5678, 1'b0, 1'b0);
        push_exp(0, 32'h0003_0000, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            step((g == 0) ? 1 : 5);
            chk("rr_owner", 32'(owner), 32'(g % 4));
        end
        req = 4'b0000;
        step(2);
        chk("rr_last_done", 32'(done), 32'b0001);
        chk("rr_op_count", 32'(op_count), 32'd5);
        step(1);
        chk("rr_done_one_cycle", 32'(done), 32'd0);
        step(2);
        chk("rr_idle", 32'(busy), 32'd0);

        step(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("done_pulse_count", 32'(done_seen), 32'(n_push));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
